id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core; sits directly downstream of the operand forwarding unit.
- Latches the already-forwarded rs/rt operands and decoded control from ID, then presents them to EX.
- Detects load-use hazards and inserts exactly one bubble while holding IF/ID.
- Handles downstream hold (ex_stall) and branch flush, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.
- CW, 16, bubble counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RW  source register index rs.
- id_rt  in  RW  source register index rt.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_rs_data  in  DW  forwarded rs operand.
- id_rt_data  in  DW  forwarded rt operand.
- id_imm  in  DW  sign/zero-extended immediate.
- id_pc  in  DW  instruction PC.
- id_dst  in  RW  destination register.
- id_we  in  1  register write enable.
- id_mem_rd  in  1  load.
- id_mem_wr  in  1  store.
- id_alu_op  in  4  ALU operation.
- flush  in  1  kill the instruction in ID (branch or jump taken).
- ex_stall  in  1  EX/MEM cannot accept; hold the EX register.
- ex_valid, ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_imm, ex_pc, ex_dst, ex_we, ex_mem_rd, ex_mem_wr, ex_alu_op  out  (widths as ID counterparts)  registered EX-stage copies.
- stall_id  out  1  hold PC and IF/ID this cycle (combinational).
- bubble_cnt  out  CW  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (async, immediate):
  - All ex_* outputs are 0.
  - bubble_cnt is 0.
  - stall_id follows its equation; it is 0 when id_valid = 0 and ex_stall = 0.
- hazard (combinational) is 1 when all of the following hold:
  - ex_valid & ex_mem_rd & (ex_dst != 0) & id_valid
  - and either (id_uses_rs & id_rs == ex_dst) or (id_uses_rt & id_rt == ex_dst).
- stall_id = ex_stall | (hazard & ~flush).
- Per-edge update priority (first match wins):
  1. ex_stall: all ex_* registers hold; bubble_cnt holds. Flush is not consumed; the source keeps flush asserted until ex_stall drops.
  2. flush: load a bubble.
  3. hazard: load a bubble; bubble_cnt += 1, saturating at 2^CW-1.
  4. otherwise: load all id_* fields. ex_valid = id_valid; when id_valid = 0, ex_we, ex_mem_rd and ex_mem_wr are forced to 0.
- Bubble definition: every ex_* field is 0. This covers valid, controls, indices and data, so dst 0 never matches forwarding.
- Latency: exactly 1 cycle from ID to EX. A load-use pair costs exactly 1 bubble. On the next cycle the load sits in MEM, hazard clears naturally, and the forwarding unit supplies the value.
- ID must hold its fields while stall_id = 1; the block relies on this.
- A load to $0 never raises a hazard.
- A store following a load with matching rt is a hazard only if id_uses_rt = 1.
- Back-to-back loads chain correctly: each dependent consumer triggers its own single bubble.
- Reset asserted mid-stall clears the state immediately; the first edge after reset release follows the normal priority order.

Test Plan:
- Reset, then id_valid=1, id_rs_data=0x1234, id_dst=3, id_we=1; one edge -> ex_rs_data=0x1234, ex_dst=3, ex_we=1, ex_valid=1, stall_id=0.
- Load lw $5 in EX (ex_mem_rd=1, ex_dst=5); ID has id_rs=5, id_uses_rs=1 -> stall_id=1, next edge gives ex_valid=0 and bubble_cnt=1. Following edge with ID held -> consumer enters EX and stall_id=0.
- Load to $0 in EX with ID reading rs=0 -> stall_id=0, no bubble, bubble_cnt unchanged.
- flush=1 together with a hazard -> stall_id=0, EX receives a bubble, bubble_cnt unchanged.
- ex_stall=1 for 3 cycles with flush=1 and new ID data -> ex_* fields frozen, stall_id=1. Drop ex_stall -> bubble loaded.
- Force bubble_cnt to 2^CW-1 via repeated hazards (CW=4 in bench) -> it stays at 15. Assert rst mid-cycle -> outputs go to 0 before the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches forwarded operands and decoded control, inserts a
// single load-use bubble, honours EX hold and branch flush, counts bubbles (saturating).
module id_ex_stage #(
   parameter int DW = 32,
   parameter int RW = 5,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic          id_uses_rs,
   input  logic          id_uses_rt,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [DW-1:0] id_pc,
   input  logic [RW-1:0] id_dst,
   input  logic          id_we,
   input  logic          id_mem_rd,
   input  logic          id_mem_wr,
   input  logic [3:0]    id_alu_op,
   input  logic          flush,
   input  logic          ex_stall,
   output logic          ex_valid,
   output logic [RW-1:0] ex_rs,
   output logic [RW-1:0] ex_rt,
   output logic [DW-1:0] ex_rs_data,
   output logic [DW-1:0] ex_rt_data,
   output logic [DW-1:0] ex_imm,
   output logic [DW-1:0] ex_pc,
   output logic [RW-1:0] ex_dst,
   output logic          ex_we,
   output logic          ex_mem_rd,
   output logic          ex_mem_wr,
   output logic [3:0]    ex_alu_op,
   output logic          stall_id,
   output logic [CW-1:0] bubble_cnt
);

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc;
      logic [RW-1:0] dst;
      logic          we;
      logic          mem_rd;
      logic          mem_wr;
      logic [3:0]    alu_op;
   } stage_t;

   stage_t        ex_q, ex_d, id_s;
   logic [CW-1:0] bubble_cnt_q, bubble_cnt_d;
   logic          dep_rs, dep_rt, hazard;

   // A load targeting $0 never produces a usable value, so it cannot cause a stall.
   assign dep_rs   = id_uses_rs & (id_rs == ex_q.dst);
   assign dep_rt   = id_uses_rt & (id_rt == ex_q.dst);
   assign hazard   = ex_q.valid & ex_q.mem_rd & (ex_q.dst != '0) & id_valid & (dep_rs | dep_rt);
   assign stall_id = ex_stall | (hazard & ~flush);

   always_comb begin
      id_s         = '0;
      id_s.valid   = id_valid;
      id_s.rs      = id_rs;
      id_s.rt      = id_rt;
      id_s.rs_data = id_rs_data;
      id_s.rt_data = id_rt_data;
      id_s.imm     = id_imm;
      id_s.pc      = id_pc;
      id_s.dst     = id_dst;
      id_s.we      = id_valid & id_we;
      id_s.mem_rd  = id_valid & id_mem_rd;
      id_s.mem_wr  = id_valid & id_mem_wr;
      id_s.alu_op  = id_alu_op;
   end

   always_comb begin
      ex_d         = ex_q;
      bubble_cnt_d = bubble_cnt_q;
      // Flush is left pending during an EX hold; the source keeps it asserted.
      if (!ex_stall) begin
         if (flush) begin
            ex_d = '0;
         end else if (hazard) begin
            ex_d = '0;
            if (bubble_cnt_q != {CW{1'b1}}) begin
               bubble_cnt_d = bubble_cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end else begin
            ex_d = id_s;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_valid   = ex_q.valid;
   assign ex_rs      = ex_q.rs;
   assign ex_rt      = ex_q.rt;
   assign ex_rs_data = ex_q.rs_data;
   assign ex_rt_data = ex_q.rt_data;
   assign ex_imm     = ex_q.imm;
   assign ex_pc      = ex_q.pc;
   assign ex_dst     = ex_q.dst;
   assign ex_we      = ex_q.we;
   assign ex_mem_rd  = ex_q.mem_rd;
   assign ex_mem_wr  = ex_q.mem_wr;
   assign ex_alu_op  = ex_q.alu_op;
   assign bubble_cnt = bubble_cnt_q;

endmodule
